// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for a router output port: SOP tagging, packet-end pulse, level/almost-full.
// Optional FIFO_PARITY_EN stores an even-parity bit per entry and flags it as par_err on read.
module router_pkt_fifo #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int AF_LVL  = 14,
   parameter int LEN_MSB = 7,
   parameter int LEN_LSB = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sft_rst,
   input  logic                     wr_en,
   input  logic                     sop,
   input  logic [DATA_W-1:0]        d_in,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        d_out,
   output logic                     d_out_vld,
   output logic                     sop_out,
   output logic                     pkt_done,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   level
`ifdef FIFO_PARITY_EN
   ,
   output logic                     par_err
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = LEN_MSB - LEN_LSB + 2;
`ifdef FIFO_PARITY_EN
   localparam int EW = DATA_W + 2;
`else
   localparam int EW = DATA_W + 1;
`endif
   localparam logic [AW:0]   P_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [RW-1:0] R_ONE = {{(RW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   AF_L  = AF_LVL[AW:0];

   logic [AW:0]   wp, rp;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] rd_ent, wr_ent;
   logic [RW-1:0] rem, len_nx;
   logic          do_wr, do_rd, clr;

   assign clr         = !rst || sft_rst;
   assign empty       = (wp == rp);
   assign full        = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign level       = wp - rp;
   assign almost_full = (level >= AF_L);
   assign do_wr       = wr_en && !full;
   assign do_rd       = rd_en && !empty;
   assign rd_ent      = mem[rp[AW-1:0]];
   // payload length plus the trailing parity byte
   assign len_nx      = {1'b0, rd_ent[LEN_MSB:LEN_LSB]} + R_ONE;

`ifdef FIFO_PARITY_EN
   assign wr_ent = {^{sop, d_in}, sop, d_in};
`else
   assign wr_ent = {sop, d_in};
`endif

   // storage is deliberately left uncleared by reset
   always_ff @(posedge clk) begin
      if (!clr && do_wr)
         mem[wp[AW-1:0]] <= wr_ent;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wp        <= '0;
         rp        <= '0;
         rem       <= '0;
         d_out     <= '0;
         d_out_vld <= 1'b0;
         sop_out   <= 1'b0;
         pkt_done  <= 1'b0;
`ifdef FIFO_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         if (do_wr)
            wp <= wp + P_ONE;
         d_out_vld <= do_rd;
         d_out     <= '0;
         sop_out   <= 1'b0;
         pkt_done  <= 1'b0;
`ifdef FIFO_PARITY_EN
         par_err   <= do_rd && (^rd_ent);
`endif
         if (do_rd) begin
            rp      <= rp + P_ONE;
            d_out   <= rd_ent[DATA_W-1:0];
            sop_out <= rd_ent[DATA_W];
            if (rd_ent[DATA_W])
               rem <= len_nx;
            else if (rem != '0) begin
               // a byte with no packet open is stray and leaves rem at zero
               rem      <= rem - R_ONE;
               pkt_done <= (rem == R_ONE);
            end
         end
      end
   end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: queue-based packet model checked every cycle plus directed literal checks.
module tb_router_pkt_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;

   logic       clk = 1'b0, rst = 1'b0, sft_rst = 1'b0;
   logic       wr_en = 1'b0, sop = 1'b0, rd_en = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic [7:0] d_out;
   logic       d_out_vld, sop_out, pkt_done, empty, full, almost_full;
   logic [4:0] level;
`ifdef FIFO_PARITY_EN
   logic       par_err;
`endif

   router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(14), .LEN_MSB(7), .LEN_LSB(2)) dut (
      .clk(clk), .rst(rst), .sft_rst(sft_rst), .wr_en(wr_en), .sop(sop), .d_in(d_in),
      .rd_en(rd_en), .d_out(d_out), .d_out_vld(d_out_vld), .sop_out(sop_out),
      .pkt_done(pkt_done), .empty(empty), .full(full), .almost_full(almost_full),
      .level(level)
`ifdef FIFO_PARITY_EN
      , .par_err(par_err)
`endif
   );

   always #5 clk = ~clk;

   int         total = 0, bad = 0;
   bit         chk_en = 1'b0;
   logic [9:0] q[$];
   int         rem_m = 0;
   logic [7:0] e_d = 8'h00;
   logic       e_vld = 1'b0, e_sop = 1'b0, e_pd = 1'b0, e_pe = 1'b0;

   logic [7:0] t3d [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] t5d [5] = '{8'h77, 8'h08, 8'hB1, 8'hB2, 8'hB3};
   logic       pd5 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: FIFO is a queue of {parity_bad, sop, data}; packets tracked as bytes remaining
   always @(posedge clk) begin : model
      logic [9:0] e;
      bit rd, wr;
      rd = 1'b0;
      wr = 1'b0;
      e  = '0;
      e_d = 8'h00; e_vld = 1'b0; e_sop = 1'b0; e_pd = 1'b0; e_pe = 1'b0;
      if (!rst || sft_rst) begin
         q.delete();
         rem_m = 0;
      end else begin
         rd = rd_en && (q.size() != 0);
         wr = wr_en && (q.size() != DEPTH);
         if (rd) begin
            e     = q.pop_front();
            e_vld = 1'b1;
            e_d   = e[7:0];
            e_sop = e[8];
            e_pe  = e[9];
            if (e[8]) rem_m = int'(e[7:2]) + 1;
            else if (rem_m > 0) begin
               rem_m--;
               e_pd = (rem_m == 0);
            end
         end
         if (wr) q.push_back({1'b0, sop, d_in});
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_d_out",   32'(d_out),       32'(e_d));
         chk("m_vld",     32'(d_out_vld),   32'(e_vld));
         chk("m_sop_out", 32'(sop_out),     32'(e_sop));
         chk("m_pkt_done",32'(pkt_done),    32'(e_pd));
         chk("m_level",   32'(level),       32'(q.size()));
         chk("m_empty",   32'(empty),       32'(q.size() == 0));
         chk("m_full",    32'(full),        32'(q.size() == DEPTH));
         chk("m_af",      32'(almost_full), 32'(q.size() >= 14));
`ifdef FIFO_PARITY_EN
         chk("m_par_err", 32'(par_err),     32'(e_pe));
`endif
      end
   end

   task automatic step(input logic w, input logic s, input logic [7:0] d, input logic r);
      wr_en = w; sop = s; d_in = d; rd_en = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0);
      chk_en = 1'b1;
      rst = 1'b1;

      // reset then idle
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 8'h00, 0);
         chk("t1_empty", 32'(empty), 32'd1);
         chk("t1_full",  32'(full),  32'd0);
         chk("t1_level", 32'(level), 32'd0);
         chk("t1_d_out", 32'(d_out), 32'd0);
         chk("t1_vld",   32'(d_out_vld), 32'd0);
      end

      // fill, overflow attempt, drain in order
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 8'(i * 3 + 1), 0);
         chk("t2_level", 32'(level), 32'(i + 1));
         chk("t2_af",    32'(almost_full), 32'(i + 1 >= 14));
      end
      chk("t2_full", 32'(full), 32'd1);
      step(1, 0, 8'hEE, 0);
      chk("t2_drop_level", 32'(level), 32'd16);
      chk("t2_drop_full",  32'(full),  32'd1);
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 8'h00, 1);
         chk("t2_rd_data", 32'(d_out), 32'(i * 3 + 1));
         chk("t2_rd_vld",  32'(d_out_vld), 32'd1);
      end
      chk("t2_empty", 32'(empty), 32'd1);
      step(0, 0, 8'h00, 1);
      chk("t2_rd_empty_vld", 32'(d_out_vld), 32'd0);
      chk("t2_rd_empty_d",   32'(d_out),     32'd0);

      // header len=3 + 3 payload + parity
      for (int i = 0; i < 5; i++) step(1, (i == 0), t3d[i], 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 8'h00, 1);
         chk("t3_data", 32'(d_out),    32'(t3d[i]));
         chk("t3_sop",  32'(sop_out),  32'(i == 0));
         chk("t3_done", 32'(pkt_done), 32'(pd5[i]));
      end
      step(0, 0, 8'h00, 0);
      chk("t3_done_clr", 32'(pkt_done), 32'd0);

      // header len=0: next byte is the parity byte
      step(1, 1, 8'h00, 0);
      step(1, 0, 8'h5A, 0);
      step(0, 0, 8'h00, 1);
      chk("t3z_hdr_done", 32'(pkt_done), 32'd0);
      step(0, 0, 8'h00, 1);
      chk("t3z_par_done", 32'(pkt_done), 32'd1);
      chk("t3z_par_data", 32'(d_out),    32'h5A);

      // steady level 5 with simultaneous read/write across pointer wraps
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i), 0);
      for (int i = 0; i < 40; i++) begin
         step(1, 0, 8'($urandom), 1);
         chk("t4_level", 32'(level), 32'd5);
      end
      for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      chk("t4_empty", 32'(empty), 32'd1);

      // soft reset mid-packet
      step(1, 1, 8'h10, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hA1 + i), 0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      chk("t5_pre_data", 32'(d_out), 32'hA1);
      sft_rst = 1'b1;
      step(0, 0, 8'h00, 0);
      sft_rst = 1'b0;
      chk("t5_empty", 32'(empty),     32'd1);
      chk("t5_level", 32'(level),     32'd0);
      chk("t5_vld",   32'(d_out_vld), 32'd0);
      for (int i = 0; i < 5; i++) step(1, (i == 1), t5d[i], 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 8'h00, 1);
         chk("t5_data", 32'(d_out),    32'(t5d[i]));
         chk("t5_sop",  32'(sop_out),  32'(i == 1));
         chk("t5_done", 32'(pkt_done), 32'(pd5[i]));
      end
      step(0, 0, 8'h00, 0);

`ifdef FIFO_PARITY_EN
      // corrupt the parity bit of the entry at address 0
      sft_rst = 1'b1;
      step(0, 0, 8'h00, 0);
      sft_rst = 1'b0;
      step(1, 0, 8'h5C, 0);
      dut.mem[0][DATA_W+1] = ~dut.mem[0][DATA_W+1];
      q[0][9] = 1'b1;
      step(1, 0, 8'h33, 0);
      step(0, 0, 8'h00, 1);
      chk("t6_perr_hit", 32'(par_err), 32'd1);
      step(0, 0, 8'h00, 1);
      chk("t6_perr_ok",  32'(par_err), 32'd0);
      step(0, 0, 8'h00, 0);
      chk("t6_perr_idle", 32'(par_err), 32'd0);
`endif

      step(0, 0, 8'h00, 0);
      @(posedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
